ldpc_ber_counter_mp: RTL and testbench

LDPC_BER_COUNTER_MP -- requirements
Module: ldpc_ber_counter_mp

---
 rtl/ldpc_ber_pkg.sv | 12 +
 rtl/ldpc_ber_popcount.sv | 50 +++++
 rtl/ldpc_ber_counter_mp.sv | 150 +++++++++++++++
 tb/tb_ldpc_ber_counter_mp.sv | 277 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/ldpc_ber_pkg.sv
// rtl/ldpc_ber_pkg.sv - shared widths and helpers for the LDPC bit-error-rate counter
package ldpc_ber_pkg;

    localparam int DEF_DATA_WIDTH = 128;
    localparam int DEF_CNT_WIDTH  = 48;
    localparam int DEF_BLK_WIDTH  = 16;

    function automatic int popcnt_width(input int data_width);
        return $clog2(data_width + 1);
    endfunction

endpackage

// File: rtl/ldpc_ber_popcount.sv
// rtl/ldpc_ber_popcount.sv - registered byte-popcount adder tree (pipeline stage 2)
module ldpc_ber_popcount
    import ldpc_ber_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH
) (
    input  logic                                clk,
    input  logic                                flush,
    input  logic                                in_valid,
    input  logic                                in_last,
    input  logic [DATA_WIDTH-1:0]               in_err,
    output logic                                out_valid,
    output logic                                out_last,
    output logic [popcnt_width(DATA_WIDTH)-1:0] out_count
);

    localparam int PW = popcnt_width(DATA_WIDTH);
    localparam int NB = DATA_WIDTH / 8;

    function automatic logic [3:0] byte_pop(input logic [7:0] b);
        logic [3:0] c;
        c = '0;
        for (int i = 0; i < 8; i++) begin
            c = c + {3'b000, b[i]};
        end
        return c;
    endfunction

    logic [PW-1:0] sum;

    always_comb begin
        sum = '0;
        for (int b = 0; b < NB; b++) begin
            sum = sum + PW'(byte_pop(in_err[b*8 +: 8]));
        end
    end

    always_ff @(posedge clk) begin
        if (flush) begin
            out_valid <= 1'b0;
            out_last  <= 1'b0;
            out_count <= '0;
        end else begin
            out_valid <= in_valid;
            out_last  <= in_last;
            out_count <= sum;
        end
    end

endmodule

// File: rtl/ldpc_ber_counter_mp.sv
// rtl/ldpc_ber_counter_mp.sv - three-stage bit/block error counter with snapshot outputs
module ldpc_ber_counter_mp
    import ldpc_ber_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int CNT_WIDTH  = DEF_CNT_WIDTH,
    parameter int BLK_WIDTH  = DEF_BLK_WIDTH
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  clear,
    input  logic                  snapshot,
    input  logic [DATA_WIDTH-1:0] expected,
    input  logic [DATA_WIDTH-1:0] last_mask,
    input  logic [DATA_WIDTH-1:0] s_axis_dout_tdata,
    input  logic                  s_axis_dout_tvalid,
    output logic                  s_axis_dout_tready,
    input  logic                  s_axis_dout_tlast,
    output logic [CNT_WIDTH-1:0]  bit_errors,
    output logic [CNT_WIDTH-1:0]  block_errors,
    output logic [CNT_WIDTH-1:0]  blocks,
    output logic [BLK_WIDTH-1:0]  max_block_errors,
    output logic                  snap_valid,
    output logic                  saturated,
    output logic                  busy
);

    localparam int PW = popcnt_width(DATA_WIDTH);
    // Extra headroom so a narrow counter can still detect overflow from a wide beat count.
    localparam int BW = ((CNT_WIDTH > PW) ? CNT_WIDTH : PW) + 1;
    localparam int AW = ((BLK_WIDTH > PW) ? BLK_WIDTH : PW) + 1;
    localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;
    localparam logic [BLK_WIDTH-1:0] BLK_MAX = '1;

    logic                  flush;
    logic                  accept;
    logic                  s1_valid;
    logic                  s1_last;
    logic [DATA_WIDTH-1:0] s1_err;
    logic                  s2_valid;
    logic                  s2_last;
    logic [PW-1:0]         s2_count;

    logic [CNT_WIDTH-1:0]  bit_live;
    logic [CNT_WIDTH-1:0]  blkerr_live;
    logic [CNT_WIDTH-1:0]  blocks_live;
    logic [BLK_WIDTH-1:0]  max_live;
    logic [BLK_WIDTH-1:0]  acc;

    logic [BW-1:0]         bit_wide;
    logic [AW-1:0]         total_wide;
    logic [CNT_WIDTH-1:0]  bit_next;
    logic [CNT_WIDTH-1:0]  blocks_next;
    logic [CNT_WIDTH-1:0]  blkerr_next;
    logic [BLK_WIDTH-1:0]  total;
    logic [BLK_WIDTH-1:0]  max_next;
    logic                  sat_hit;

    assign flush              = reset | clear;
    assign s_axis_dout_tready = ~flush;
    assign accept             = s_axis_dout_tvalid & s_axis_dout_tready;
    assign busy               = s1_valid | s2_valid;

    always_ff @(posedge clk) begin
        if (flush) begin
            s1_valid <= 1'b0;
            s1_last  <= 1'b0;
            s1_err   <= '0;
        end else begin
            s1_valid <= accept;
            if (accept) begin
                s1_last <= s_axis_dout_tlast;
                s1_err  <= (s_axis_dout_tdata ^ expected)
                           & (s_axis_dout_tlast ? last_mask : {DATA_WIDTH{1'b1}});
            end
        end
    end

    ldpc_ber_popcount #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_popcount (
        .clk       (clk),
        .flush     (flush),
        .in_valid  (s1_valid),
        .in_last   (s1_last),
        .in_err    (s1_err),
        .out_valid (s2_valid),
        .out_last  (s2_last),
        .out_count (s2_count)
    );

    always_comb begin
        bit_wide    = BW'(bit_live) + BW'(s2_count);
        bit_next    = (bit_wide > BW'(CNT_MAX)) ? CNT_MAX : bit_wide[CNT_WIDTH-1:0];
        total_wide  = AW'(acc) + AW'(s2_count);
        total       = (total_wide > AW'(BLK_MAX)) ? BLK_MAX : total_wide[BLK_WIDTH-1:0];
        blocks_next = (blocks_live == CNT_MAX) ? blocks_live : blocks_live + CNT_WIDTH'(1);
        blkerr_next = (blkerr_live == CNT_MAX || total == '0) ? blkerr_live
                                                              : blkerr_live + CNT_WIDTH'(1);
        max_next    = (total > max_live) ? total : max_live;
        sat_hit     = s2_valid && ((bit_next == CNT_MAX) ||
                      (s2_last && (blocks_next == CNT_MAX || blkerr_next == CNT_MAX)));
    end

    always_ff @(posedge clk) begin
        if (flush) begin
            bit_live    <= '0;
            blkerr_live <= '0;
            blocks_live <= '0;
            max_live    <= '0;
            acc         <= '0;
            saturated   <= 1'b0;
        end else begin
            if (s2_valid) begin
                bit_live <= bit_next;
                if (s2_last) begin
                    blocks_live <= blocks_next;
                    blkerr_live <= blkerr_next;
                    max_live    <= max_next;
                    acc         <= '0;
                end else begin
                    acc <= total;
                end
            end
            if (sat_hit) begin
                saturated <= 1'b1;
            end
        end
    end

    // Snapshot copies the registered live values, so a same-edge update or clear is excluded.
    always_ff @(posedge clk) begin
        if (reset) begin
            bit_errors       <= '0;
            block_errors     <= '0;
            blocks           <= '0;
            max_block_errors <= '0;
            snap_valid       <= 1'b0;
        end else begin
            snap_valid <= snapshot;
            if (snapshot) begin
                bit_errors       <= bit_live;
                block_errors     <= blkerr_live;
                blocks           <= blocks_live;
                max_block_errors <= max_live;
            end
        end
    end

endmodule

// File: tb/tb_ldpc_ber_counter_mp.sv
// tb/tb_ldpc_ber_counter_mp.sv - directed self-checking bench for ldpc_ber_counter_mp
module tb_ldpc_ber_counter_mp;

    localparam int DW = 128;

    logic          clk;
    logic          rst;
    logic          clr;
    logic          snap;
    logic [DW-1:0] expected_w;
    logic [DW-1:0] last_mask_w;
    logic [DW-1:0] tdata;
    logic          tvalid;
    logic          tlast;

    logic          tready;
    logic [47:0]   bit_errors;
    logic [47:0]   block_errors;
    logic [47:0]   blocks;
    logic [15:0]   max_be;
    logic          snap_valid;
    logic          saturated;
    logic          busy;

    logic          tready_s;
    logic [3:0]    bit_errors_s;
    logic [3:0]    block_errors_s;
    logic [3:0]    blocks_s;
    logic [15:0]   max_be_s;
    logic          snap_valid_s;
    logic          saturated_s;
    logic          busy_s;

    int n_cmp;
    int n_bad;

    ldpc_ber_counter_mp dut (
        .clk                (clk),
        .reset              (rst),
        .clear              (clr),
        .snapshot           (snap),
        .expected           (expected_w),
        .last_mask          (last_mask_w),
        .s_axis_dout_tdata  (tdata),
        .s_axis_dout_tvalid (tvalid),
        .s_axis_dout_tready (tready),
        .s_axis_dout_tlast  (tlast),
        .bit_errors         (bit_errors),
        .block_errors       (block_errors),
        .blocks             (blocks),
        .max_block_errors   (max_be),
        .snap_valid         (snap_valid),
        .saturated          (saturated),
        .busy               (busy)
    );

    ldpc_ber_counter_mp #(
        .CNT_WIDTH (4)
    ) dut_small (
        .clk                (clk),
        .reset              (rst),
        .clear              (clr),
        .snapshot           (snap),
        .expected           (expected_w),
        .last_mask          (last_mask_w),
        .s_axis_dout_tdata  (tdata),
        .s_axis_dout_tvalid (tvalid),
        .s_axis_dout_tready (tready_s),
        .s_axis_dout_tlast  (tlast),
        .bit_errors         (bit_errors_s),
        .block_errors       (block_errors_s),
        .blocks             (blocks_s),
        .max_block_errors   (max_be_s),
        .snap_valid         (snap_valid_s),
        .saturated          (saturated_s),
        .busy               (busy_s)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic beat(input logic [DW-1:0] d, input logic l);
        tvalid = 1'b1;
        tdata  = d;
        tlast  = l;
        @(negedge clk);
        tvalid = 1'b0;
        tlast  = 1'b0;
        tdata  = '0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic do_clear();
        clr = 1'b1;
        @(negedge clk);
        clr = 1'b0;
    endtask

    task automatic do_snap();
        snap = 1'b1;
        @(negedge clk);
        snap = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        idle(2);
        n_cmp++; if (tready !== 1'b0) begin n_bad++; $display("FAIL reset_tready: got %0b want 0", tready); end
        n_cmp++; if (bit_errors !== 48'd0) begin n_bad++; $display("FAIL reset_bit_errors: got %0d want 0", bit_errors); end
        n_cmp++; if (blocks !== 48'd0) begin n_bad++; $display("FAIL reset_blocks: got %0d want 0", blocks); end
        n_cmp++; if (snap_valid !== 1'b0) begin n_bad++; $display("FAIL reset_snap_valid: got %0b want 0", snap_valid); end
        n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL reset_busy: got %0b want 0", busy); end
        n_cmp++; if (saturated !== 1'b0) begin n_bad++; $display("FAIL reset_saturated: got %0b want 0", saturated); end
        rst = 1'b0;
        #1;
        n_cmp++; if (tready !== 1'b1) begin n_bad++; $display("FAIL ready_after_reset: got %0b want 1", tready); end
        idle(1);
    endtask

    task automatic test_basic();
        do_clear();
        beat(128'h7, 1'b0);
        beat(128'h0, 1'b0);
        beat(128'h1_0000_0000_0000_0000_0000_000F, 1'b0);
        beat(128'h1, 1'b1);
        idle(3);
        do_snap();
        n_cmp++; if (bit_errors !== 48'd9) begin n_bad++; $display("FAIL basic_bit_errors: got %0d want 9", bit_errors); end
        n_cmp++; if (blocks !== 48'd1) begin n_bad++; $display("FAIL basic_blocks: got %0d want 1", blocks); end
        n_cmp++; if (block_errors !== 48'd1) begin n_bad++; $display("FAIL basic_block_errors: got %0d want 1", block_errors); end
        n_cmp++; if (max_be !== 16'd9) begin n_bad++; $display("FAIL basic_max: got %0d want 9", max_be); end
        n_cmp++; if (snap_valid !== 1'b1) begin n_bad++; $display("FAIL basic_snap_valid_hi: got %0b want 1", snap_valid); end
        idle(1);
        n_cmp++; if (snap_valid !== 1'b0) begin n_bad++; $display("FAIL basic_snap_valid_lo: got %0b want 0", snap_valid); end
    endtask

    task automatic test_multi_block();
        beat(128'h3, 1'b1);
        beat(128'h0, 1'b1);
        idle(3);
        do_snap();
        n_cmp++; if (bit_errors !== 48'd11) begin n_bad++; $display("FAIL multi_bit_errors: got %0d want 11", bit_errors); end
        n_cmp++; if (blocks !== 48'd3) begin n_bad++; $display("FAIL multi_blocks: got %0d want 3", blocks); end
        n_cmp++; if (block_errors !== 48'd2) begin n_bad++; $display("FAIL multi_block_errors: got %0d want 2", block_errors); end
        n_cmp++; if (max_be !== 16'd9) begin n_bad++; $display("FAIL multi_max: got %0d want 9", max_be); end
    endtask

    task automatic test_last_mask();
        do_clear();
        last_mask_w = 128'hFFFF_FFFF;
        beat({DW{1'b1}}, 1'b0);
        beat({DW{1'b1}}, 1'b1);
        last_mask_w = {DW{1'b1}};
        idle(3);
        do_snap();
        n_cmp++; if (bit_errors !== 48'd160) begin n_bad++; $display("FAIL mask_bit_errors: got %0d want 160", bit_errors); end
        n_cmp++; if (max_be !== 16'd160) begin n_bad++; $display("FAIL mask_max: got %0d want 160", max_be); end
        n_cmp++; if (blocks !== 48'd1) begin n_bad++; $display("FAIL mask_blocks: got %0d want 1", blocks); end
    endtask

    task automatic test_back_to_back();
        do_clear();
        expected_w = {DW{1'b1}};
        tvalid = 1'b1;
        tdata  = {DW{1'b1}};
        tlast  = 1'b1;
        repeat (10) @(negedge clk);
        tvalid = 1'b0;
        tlast  = 1'b0;
        snap   = 1'b1;
        #1;
        n_cmp++; if (busy !== 1'b1) begin n_bad++; $display("FAIL b2b_busy: got %0b want 1", busy); end
        @(negedge clk);
        snap = 1'b0;
        n_cmp++; if (blocks !== 48'd8) begin n_bad++; $display("FAIL b2b_blocks_first: got %0d want 8", blocks); end
        n_cmp++; if (block_errors !== 48'd0) begin n_bad++; $display("FAIL b2b_block_errors_first: got %0d want 0", block_errors); end
        n_cmp++; if (snap_valid !== 1'b1) begin n_bad++; $display("FAIL b2b_snap_valid: got %0b want 1", snap_valid); end
        idle(2);
        do_snap();
        n_cmp++; if (blocks !== 48'd10) begin n_bad++; $display("FAIL b2b_blocks_second: got %0d want 10", blocks); end
        n_cmp++; if (block_errors !== 48'd0) begin n_bad++; $display("FAIL b2b_block_errors_second: got %0d want 0", block_errors); end
        n_cmp++; if (bit_errors !== 48'd0) begin n_bad++; $display("FAIL b2b_bit_errors: got %0d want 0", bit_errors); end
        n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL b2b_idle_busy: got %0b want 0", busy); end
        expected_w = '0;
    endtask

    task automatic test_saturation();
        do_clear();
        for (int i = 0; i < 20; i++) begin
            beat(128'h1, 1'b1);
        end
        idle(3);
        do_snap();
        n_cmp++; if (blocks_s !== 4'd15) begin n_bad++; $display("FAIL sat_blocks: got %0d want 15", blocks_s); end
        n_cmp++; if (bit_errors_s !== 4'd15) begin n_bad++; $display("FAIL sat_bit_errors: got %0d want 15", bit_errors_s); end
        n_cmp++; if (block_errors_s !== 4'd15) begin n_bad++; $display("FAIL sat_block_errors: got %0d want 15", block_errors_s); end
        n_cmp++; if (saturated_s !== 1'b1) begin n_bad++; $display("FAIL sat_flag: got %0b want 1", saturated_s); end
        n_cmp++; if (saturated !== 1'b0) begin n_bad++; $display("FAIL sat_wide_flag: got %0b want 0", saturated); end
        n_cmp++; if (blocks !== 48'd20) begin n_bad++; $display("FAIL sat_wide_blocks: got %0d want 20", blocks); end
        do_clear();
        do_snap();
        n_cmp++; if (blocks_s !== 4'd0) begin n_bad++; $display("FAIL sat_clr_blocks: got %0d want 0", blocks_s); end
        n_cmp++; if (bit_errors_s !== 4'd0) begin n_bad++; $display("FAIL sat_clr_bit_errors: got %0d want 0", bit_errors_s); end
        n_cmp++; if (block_errors_s !== 4'd0) begin n_bad++; $display("FAIL sat_clr_block_errors: got %0d want 0", block_errors_s); end
        n_cmp++; if (max_be_s !== 16'd0) begin n_bad++; $display("FAIL sat_clr_max: got %0d want 0", max_be_s); end
        n_cmp++; if (saturated_s !== 1'b0) begin n_bad++; $display("FAIL sat_clr_flag: got %0b want 0", saturated_s); end
    endtask

    task automatic test_clear_snapshot();
        do_clear();
        beat(128'h1F, 1'b1);
        idle(3);
        clr  = 1'b1;
        snap = 1'b1;
        #1;
        n_cmp++; if (tready !== 1'b0) begin n_bad++; $display("FAIL clr_tready: got %0b want 0", tready); end
        @(negedge clk);
        clr  = 1'b0;
        snap = 1'b0;
        n_cmp++; if (bit_errors !== 48'd5) begin n_bad++; $display("FAIL clrsnap_bit_errors: got %0d want 5", bit_errors); end
        n_cmp++; if (blocks !== 48'd1) begin n_bad++; $display("FAIL clrsnap_blocks: got %0d want 1", blocks); end
        do_snap();
        n_cmp++; if (bit_errors !== 48'd0) begin n_bad++; $display("FAIL clrsnap_after_bit_errors: got %0d want 0", bit_errors); end
        n_cmp++; if (blocks !== 48'd0) begin n_bad++; $display("FAIL clrsnap_after_blocks: got %0d want 0", blocks); end
    endtask

    task automatic test_reset_mid_block();
        do_clear();
        beat(128'h7, 1'b0);
        beat(128'hF, 1'b0);
        rst = 1'b1;
        idle(2);
        rst = 1'b0;
        beat(128'h3, 1'b1);
        idle(3);
        do_snap();
        n_cmp++; if (blocks !== 48'd1) begin n_bad++; $display("FAIL rstmid_blocks: got %0d want 1", blocks); end
        n_cmp++; if (bit_errors !== 48'd2) begin n_bad++; $display("FAIL rstmid_bit_errors: got %0d want 2", bit_errors); end
        n_cmp++; if (max_be !== 16'd2) begin n_bad++; $display("FAIL rstmid_max: got %0d want 2", max_be); end
        n_cmp++; if (block_errors !== 48'd1) begin n_bad++; $display("FAIL rstmid_block_errors: got %0d want 1", block_errors); end
    endtask

    initial begin
        n_cmp       = 0;
        n_bad       = 0;
        rst         = 1'b1;
        clr         = 1'b0;
        snap        = 1'b0;
        expected_w  = '0;
        last_mask_w = {DW{1'b1}};
        tdata       = '0;
        tvalid      = 1'b0;
        tlast       = 1'b0;

        test_reset();
        test_basic();
        test_multi_block();
        test_last_mask();
        test_back_to_back();
        test_saturation();
        test_clear_snapshot();
        test_reset_mid_block();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
